// File: rtl/sd_pkg.sv
// Shared SD definitions: buffer direction enum and block size.
// Imported by sd_dat_buffer and any other SD-side blocks.
package sd_pkg;

  typedef enum logic {
    SD_BUF_TX = 1'b0,
    SD_BUF_RX = 1'b1
  } sd_buf_mode_e;

  localparam int unsigned SD_BLK_BYTES = 512;

endpackage

// File: rtl/sd_dat_buffer.sv
// SD data buffer: byte circular array bridging a 16-bit DMA side
// and an 8-bit SD side. rx_mode picks direction; flush empties.
// Ports: clk, reset (async high), rx_mode, flush,
//   dma_write/dma_wdata/dma_wfull, dma_read/dma_rdata/dma_rempty,
//   sd_write/sd_wdata/sd_full, sd_read/sd_rdata/sd_empty,
//   count (bytes stored), overflow/underflow (sticky).
module sd_dat_buffer
  import sd_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_mode,
  input  logic                     flush,
  input  logic                     dma_write,
  input  logic [15:0]              dma_wdata,
  output logic                     dma_wfull,
  input  logic                     dma_read,
  output logic [15:0]              dma_rdata,
  output logic                     dma_rempty,
  input  logic                     sd_write,
  input  logic [7:0]               sd_wdata,
  output logic                     sd_full,
  input  logic                     sd_read,
  output logic [7:0]               sd_rdata,
  output logic                     sd_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [15:0]   dma_rdata_q, dma_rdata_d;
  logic [7:0]    sd_rdata_q, sd_rdata_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  sd_buf_mode_e  mode_q, mode_d;

  sd_buf_mode_e  mode_in;
  logic [PW-1:0] cnt;
  logic          is_tx, flush_e;
  logic          wr_req, wr_blk, wr_ok;
  logic          rd_req, rd_blk, rd_ok;
  logic [AW-1:0] wa0, wa1, ra0, ra1;
  logic          we0, we1;
  logic [7:0]    wd0, wd1;

  assign mode_in    = sd_buf_mode_e'(rx_mode);
  assign cnt        = wptr_q - rptr_q;
  assign count      = cnt;
  assign sd_empty   = (cnt == '0);
  assign sd_full    = (cnt == PW'(DEPTH));
  assign dma_rempty = (cnt < PW'(2));
  assign dma_wfull  = (cnt > PW'(DEPTH - 2));

  assign dma_rdata  = dma_rdata_q;
  assign sd_rdata   = sd_rdata_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

  always_comb begin
    mode_d      = mode_in;
    is_tx       = (mode_in == SD_BUF_TX);
    // a direction change drains the buffer like a flush
    flush_e     = flush | (mode_in != mode_q);
    wr_req      = is_tx ? dma_write : sd_write;
    wr_blk      = is_tx ? dma_wfull : sd_full;
    rd_req      = is_tx ? sd_read : dma_read;
    rd_blk      = is_tx ? sd_empty : dma_rempty;
    wr_ok       = !flush_e && wr_req && !wr_blk;
    rd_ok       = !flush_e && rd_req && !rd_blk;
    wa0         = wptr_q[AW-1:0];
    wa1         = wa0 + AW'(1);
    ra0         = rptr_q[AW-1:0];
    ra1         = ra0 + AW'(1);
    we0         = wr_ok;
    we1         = wr_ok && is_tx;
    wd0         = is_tx ? dma_wdata[15:8] : sd_wdata;
    wd1         = dma_wdata[7:0];
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    dma_rdata_d = dma_rdata_q;
    sd_rdata_d  = sd_rdata_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (flush_e) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (wr_req && wr_blk) ovf_d = 1'b1;
      if (rd_req && rd_blk) unf_d = 1'b1;
      if (wr_ok) begin
        wptr_d = wptr_q + (is_tx ? PW'(2) : PW'(1));
      end
      if (rd_ok) begin
        if (is_tx) begin
          sd_rdata_d = mem_q[ra0];
          rptr_d     = rptr_q + PW'(1);
        end else begin
          dma_rdata_d = {mem_q[ra0], mem_q[ra1]};
          rptr_d      = rptr_q + PW'(2);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      dma_rdata_q <= 16'h0000;
      sd_rdata_q  <= 8'h00;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      mode_q      <= SD_BUF_TX;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      dma_rdata_q <= dma_rdata_d;
      sd_rdata_q  <= sd_rdata_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      mode_q      <= mode_d;
    end
  end

  // storage carries no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (we0) mem_q[wa0] <= wd0;
    if (we1) mem_q[wa1] <= wd1;
  end

endmodule

// File: tb/tb_sd_dat_buffer.sv
// Testbench for sd_dat_buffer: DEPTH=16 instance driven by a
// byte-queue model, plus a DEPTH=1024 instance for long TX runs.
module tb_sd_dat_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        s_rx, s_fl, s_dw, s_dr, s_sw, s_sr;
  logic [15:0] s_wd, s_dma_rdata;
  logic [7:0]  s_swd, s_sd_rdata;
  logic        s_wfull, s_rempty, s_full, s_empty;
  logic        s_ovf, s_unf;
  logic [4:0]  s_count;

  logic        b_dw, b_sr;
  logic [15:0] b_wd, b_dma_rdata;
  logic [7:0]  b_sd_rdata;
  logic        b_wfull, b_rempty, b_full, b_empty;
  logic        b_ovf, b_unf;
  logic [10:0] b_count;

  sd_dat_buffer #(.DEPTH(16)) u_small (
    .clk(clk), .reset(reset), .rx_mode(s_rx), .flush(s_fl),
    .dma_write(s_dw), .dma_wdata(s_wd), .dma_wfull(s_wfull),
    .dma_read(s_dr), .dma_rdata(s_dma_rdata),
    .dma_rempty(s_rempty),
    .sd_write(s_sw), .sd_wdata(s_swd), .sd_full(s_full),
    .sd_read(s_sr), .sd_rdata(s_sd_rdata), .sd_empty(s_empty),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sd_dat_buffer #(.DEPTH(1024)) u_big (
    .clk(clk), .reset(reset), .rx_mode(1'b0), .flush(1'b0),
    .dma_write(b_dw), .dma_wdata(b_wd), .dma_wfull(b_wfull),
    .dma_read(1'b0), .dma_rdata(b_dma_rdata),
    .dma_rempty(b_rempty),
    .sd_write(1'b0), .sd_wdata(8'h00), .sd_full(b_full),
    .sd_read(b_sr), .sd_rdata(b_sd_rdata), .sd_empty(b_empty),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  mq [$];
  logic [7:0]  qb [$];
  bit          m_ovf, m_unf, m_rxq;
  logic [7:0]  m_sd;
  logic [15:0] m_dma;

  typedef struct {
    string       nm;
    bit          rx;
    bit          dw;
    logic [15:0] wd;
    bit          dr;
    bit          sw;
    logic [7:0]  swd;
    bit          sr;
    bit          fl;
    int          ecnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm);
    int n;
    n = mq.size();
    chk({nm, ".count"}, 32'(s_count), n);
    chk({nm, ".wfull"}, 32'(s_wfull), 32'(n > 14));
    chk({nm, ".rempty"}, 32'(s_rempty), 32'(n < 2));
    chk({nm, ".full"}, 32'(s_full), 32'(n == 16));
    chk({nm, ".empty"}, 32'(s_empty), 32'(n == 0));
    chk({nm, ".ovf"}, 32'(s_ovf), 32'(m_ovf));
    chk({nm, ".unf"}, 32'(s_unf), 32'(m_unf));
    chk({nm, ".sd_rdata"}, 32'(s_sd_rdata), 32'(m_sd));
    chk({nm, ".dma_rdata"}, 32'(s_dma_rdata), 32'(m_dma));
  endtask

  task automatic step(string nm, bit rx, bit dw,
                      logic [15:0] wd, bit dr, bit sw,
                      logic [7:0] swd, bit sr, bit fl);
    int n;
    s_rx = rx; s_dw = dw; s_wd = wd; s_dr = dr;
    s_sw = sw; s_swd = swd; s_sr = sr; s_fl = fl;
    n = mq.size();
    if (fl || (rx != m_rxq)) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!rx) begin
      if (sr) begin
        if (n == 0) m_unf = 1'b1;
        else m_sd = mq.pop_front();
      end
      if (dw) begin
        if (n > 14) m_ovf = 1'b1;
        else begin
          mq.push_back(wd[15:8]);
          mq.push_back(wd[7:0]);
        end
      end
    end else begin
      if (dr) begin
        if (n < 2) m_unf = 1'b1;
        else begin
          m_dma[15:8] = mq.pop_front();
          m_dma[7:0]  = mq.pop_front();
        end
      end
      if (sw) begin
        if (n == 16) m_ovf = 1'b1;
        else mq.push_back(swd);
      end
    end
    m_rxq = rx;
    @(posedge clk);
    #1;
    s_dw = 0; s_dr = 0; s_sw = 0; s_sr = 0; s_fl = 0;
    check_all(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e;
    reset = 1'b1;
    s_rx = 0; s_fl = 0; s_dw = 0; s_dr = 0; s_sw = 0; s_sr = 0;
    s_wd = 16'h0; s_swd = 8'h0;
    b_dw = 0; b_sr = 0; b_wd = 16'h0;
    m_ovf = 0; m_unf = 0; m_rxq = 0; m_sd = 8'h00; m_dma = 16'h0;
    #1;
    check_all("reset");
    chk("big_reset.count", 32'(b_count), 0);
    chk("big_reset.empty", 32'(b_empty), 1);
    chk("big_reset.wfull", 32'(b_wfull), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    tbl[0]  = '{"tx_w1", 0, 1, 16'hA0B1, 0, 0, 8'h00, 0, 0, 2};
    tbl[1]  = '{"tx_w2", 0, 1, 16'hC2D3, 0, 0, 8'h00, 0, 0, 4};
    tbl[2]  = '{"tx_r1", 0, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 3};
    tbl[3]  = '{"tx_rw", 0, 1, 16'hE4F5, 0, 0, 8'h00, 1, 0, 4};
    tbl[4]  = '{"tx_ign", 0, 0, 16'h0000, 1, 1, 8'h99, 0, 0, 4};
    tbl[5]  = '{"flush", 0, 1, 16'h1234, 0, 0, 8'h00, 0, 1, 0};
    tbl[6]  = '{"tx_unf", 0, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0};
    tbl[7]  = '{"to_rx", 1, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0};
    tbl[8]  = '{"rx_w1", 1, 0, 16'h0000, 0, 1, 8'h11, 0, 0, 1};
    tbl[9]  = '{"rx_unf", 1, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 1};
    tbl[10] = '{"rx_w2", 1, 0, 16'h0000, 0, 1, 8'h22, 0, 0, 2};
    tbl[11] = '{"rx_rd", 1, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 0};
    tbl[12] = '{"rx_ign", 1, 1, 16'h5555, 0, 0, 8'h00, 1, 0, 0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].nm, tbl[i].rx, tbl[i].dw, tbl[i].wd,
           tbl[i].dr, tbl[i].sw, tbl[i].swd, tbl[i].sr,
           tbl[i].fl);
      chk({tbl[i].nm, ".tbl_cnt"}, 32'(s_count), tbl[i].ecnt);
    end
    chk("rx_rd.word", 32'(m_dma), 32'h1122);

    // TX ordering through the large buffer
    for (int i = 0; i < 256; i++) begin
      b_dw = 1'b1;
      b_wd = 16'hA0B1 + 16'(i);
      qb.push_back(b_wd[15:8]);
      qb.push_back(b_wd[7:0]);
      @(posedge clk);
      #1;
      b_dw = 1'b0;
    end
    chk("big.count512", 32'(b_count), 512);
    for (int i = 0; i < 512; i++) begin
      b_sr = 1'b1;
      @(posedge clk);
      #1;
      b_sr = 1'b0;
      e = qb.pop_front();
      chk("big.order", 32'(b_sd_rdata), 32'(e));
    end
    chk("big.end_count", 32'(b_count), 0);
    chk("big.end_empty", 32'(b_empty), 1);

    // RX odd-offset wrap
    step("wrap_fl", 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++)
      step("wrap_w", 1, 0, 0, 0, 1, 8'h40 + 8'(i), 0, 0);
    for (int i = 0; i < 7; i++)
      step("wrap_r", 1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 15; i < 18; i++)
      step("wrap_w2", 1, 0, 0, 0, 1, 8'h40 + 8'(i), 0, 0);
    step("wrap_r2", 1, 0, 0, 1, 0, 0, 0, 0);
    chk("wrap.word", 32'(s_dma_rdata), 32'h4E4F);
    chk("wrap.count", 32'(s_count), 2);

    // simultaneous RX write and read
    step("sim_fl", 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i < 5; i++)
      step("sim_w", 1, 0, 0, 0, 1, 8'h70 + 8'(i), 0, 0);
    step("sim_rw", 1, 0, 0, 1, 1, 8'h75, 0, 0);
    chk("sim.count", 32'(s_count), 3);
    chk("sim.word", 32'(s_dma_rdata), 32'h7172);

    // TX overflow
    step("ovf_tx", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step("ovf_w", 0, 1, {8'h10 + 8'(i), 8'h20 + 8'(i)},
           0, 0, 0, 0, 0);
    chk("ovf.wfull", 32'(s_wfull), 1);
    chk("ovf.count16", 32'(s_count), 16);
    step("ovf_w9", 0, 1, 16'hDEAD, 0, 0, 0, 0, 0);
    chk("ovf.flag", 32'(s_ovf), 1);
    chk("ovf.count", 32'(s_count), 16);
    for (int i = 0; i < 16; i++) begin
      step("ovf_r", 0, 0, 0, 0, 0, 0, 1, 0);
      chk("ovf.no_dead",
          32'(s_sd_rdata != 8'hDE && s_sd_rdata != 8'hAD), 1);
    end

    // underflow on empty, hold, then flush clears
    step("unf_r", 0, 0, 0, 0, 0, 0, 1, 0);
    chk("unf.flag", 32'(s_unf), 1);
    chk("unf.hold", 32'(s_sd_rdata), 32'h27);
    step("unf_fl", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("unf.cleared", 32'(s_unf), 0);

    // mode toggle flushes
    for (int i = 0; i < 3; i++)
      step("mode_w", 0, 1, 16'h3300 + 16'(i), 0, 0, 0, 0, 0);
    chk("mode.count6", 32'(s_count), 6);
    step("mode_tog", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("mode.count0", 32'(s_count), 0);
    step("mode_back", 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_w1", 0, 1, 16'h5A5B, 0, 0, 0, 0, 0);
    step("rst_w2", 0, 1, 16'h5C5D, 0, 0, 0, 0, 0);
    step("rst_r", 0, 0, 0, 0, 0, 0, 1, 0);

    // reset asserted mid-burst, checked before any edge
    s_dw = 1'b1;
    s_wd = 16'h6677;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    s_dw = 1'b0;
    mq.delete();
    m_ovf = 0; m_unf = 0; m_rxq = 0;
    m_sd = 8'h00; m_dma = 16'h0000;
    check_all("rst_mid");
    chk("rst_mid.big_count", 32'(b_count), 0);
    chk("rst_mid.big_empty", 32'(b_empty), 1);
    #2;
    reset = 1'b0;
    step("post_w", 0, 1, 16'h8899, 0, 0, 0, 0, 0);
    step("post_r", 0, 0, 0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_dat_buffer.md
SD_DAT_BUFFER -- requirements
Module: sd_dat_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the byte capacity, a power of two, 16 to 4096.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port rx_mode, input, 1: 0 means TX (DMA writes, SD reads); 1 means RX (SD writes, DMA reads).
REQ-005 SHALL have port flush, input, 1: single-cycle strobe that empties the buffer.
REQ-006 SHALL have ports dma_write (input, 1), dma_wdata (input, 16) and dma_wfull (output, 1, high when fewer than 2 bytes are free).
REQ-007 SHALL have ports dma_read (input, 1), dma_rdata (output, 16) and dma_rempty (output, 1, high when fewer than 2 bytes are stored).
REQ-008 SHALL have ports sd_write (input, 1), sd_wdata (input, 8) and sd_full (output, 1, high when 0 bytes are free).
REQ-009 SHALL have ports sd_read (input, 1), sd_rdata (output, 8) and sd_empty (output, 1, high when 0 bytes are stored).
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of bytes stored.
REQ-011 SHALL have ports overflow and underflow, outputs, 1 bit each, sticky error flags.

Function
REQ-012 SHALL hold bytes in a circular array, with write and read pointers one bit wider than the address; count = wptr - rptr, modulo 2^(width).
REQ-013 SHALL, in TX mode, on dma_write with !dma_wfull, store dma_wdata[15:8] at wptr and dma_wdata[7:0] at wptr+1, then advance wptr by 2, all in one cycle.
REQ-014 SHALL, in TX mode, on sd_read with !sd_empty, register the byte at rptr into sd_rdata on the next edge and advance rptr by 1 (latency: 1 cycle).
REQ-015 SHALL, in RX mode, on sd_write with !sd_full, store sd_wdata at wptr and advance wptr by 1.
REQ-016 SHALL, in RX mode, on dma_read with !dma_rempty, register {byte[rptr], byte[rptr+1]} into dma_rdata on the next edge and advance rptr by 2; pointer wrap at any byte alignment is legal.
REQ-017 SHALL ignore strobes on the side that is inactive for the current mode, with no flag set.
REQ-018 SHALL, on a write attempt while the corresponding full flag is high, drop the data, leave pointers unchanged and set overflow.
REQ-019 SHALL, on a read attempt while the corresponding empty flag is high, hold rdata, leave pointers unchanged and set underflow.
REQ-020 SHALL evaluate full/empty flags from pre-edge state, so a simultaneous read does not free space for a write in the same cycle, and a simultaneous write does not supply data for a read in the same cycle.
REQ-021 SHALL, on simultaneous valid read and write, perform both operations; count changes by the net byte delta (+1 or -1 under mixed widths, for example).
REQ-022 SHALL, on flush, zero both pointers and clear overflow/underflow, with priority over all same-cycle strobes; rdata registers keep their values.
REQ-023 SHALL treat any change of rx_mode, detected against a registered copy, as an implicit flush in the same cycle.
REQ-024 SHALL derive all status outputs combinationally from the pointers, so they are valid in the cycle after the update.

Reset
REQ-025 SHALL, on reset assertion, asynchronously set wptr=0, rptr=0, dma_rdata=16'h0000, sd_rdata=8'h00, overflow=0, underflow=0 and registered rx_mode=0.
REQ-026 SHALL therefore come out of reset with count=0, sd_empty=1, dma_rempty=1, sd_full=0 and dma_wfull=0.
REQ-027 SHALL, on reset mid-transfer, discard all stored data; array contents are don't-care.

Structure
REQ-028 SHALL be implemented as a single module without sub-modules; the array SHALL be distributed/register storage supporting two byte reads and two byte writes per cycle.
REQ-029 SHALL define a mode enum (SD_BUF_TX, SD_BUF_RX) in the shared sd package, alongside the SD block size constant (512 bytes).

Verification
REQ-030 SHALL verify TX ordering: 256 DMA writes of 16'hA0B1..; 512 SD reads then return A0, B1, ... in order, and the buffer ends with count=0 and sd_empty=1.
REQ-031 SHALL verify RX odd-offset wrap: with DEPTH=16, write 15 bytes, read 7 words, write 3 bytes (wptr wraps) and read 1 word; that word equals {byte14, byte15}, and count=2.
REQ-032 SHALL verify overflow: in TX with DEPTH=16, after 8 writes dma_wfull=1; a 9th write with 16'hDEAD sets overflow, count stays 16, and the data is never read back.
REQ-033 SHALL verify underflow: sd_read on an empty buffer sets underflow and sd_rdata holds its prior value; a subsequent flush clears underflow.
REQ-034 SHALL verify simultaneous access: in RX with count=4, sd_write and dma_read in the same cycle leave count=3 and return the oldest word.
REQ-035 SHALL verify mode change and reset: toggling rx_mode with count=6 makes count=0 on the next cycle; asserting reset mid-burst drives all outputs to their REQ-025/REQ-026 values without a clock edge.
